// File: rtl/decoder_sequencer_if.sv
// Control/strobe bundle for decoder_sequencer: the controller drives the master
// side, the decoder implements the slave side.
interface decoder_sequencer_if #(
  parameter int SEL_WIDTH  = 4,
  parameter int HOLD_WIDTH = 8
);
  localparam int OUT_COUNT = 2 ** SEL_WIDTH;

  logic                  enable;
  logic                  mode;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  start;
  logic [SEL_WIDTH-1:0]  last;
  logic [HOLD_WIDTH-1:0] hold;
  logic [OUT_COUNT-1:0]  decoder_out;
  logic                  busy;
  logic                  done;

  modport master (
    output enable, mode, sel, start, last, hold,
    input  decoder_out, busy, done
  );

  modport slave (
    input  enable, mode, sel, start, last, hold,
    output decoder_out, busy, done
  );
endinterface

// File: rtl/decoder_sequencer.sv
// Registered one-hot decoder with a stepped strobe sequencer (direct / scan modes).
// Define DECODER_SEQUENCER_GAP_EN to insert a one-cycle all-zero gap between strobes.
module decoder_sequencer #(
  parameter int SEL_WIDTH  = 4,
  parameter int HOLD_WIDTH = 8
) (
  input logic                clock,
  input logic                reset_n,
  decoder_sequencer_if.slave bus
);
  localparam int OUT_COUNT = 2 ** SEL_WIDTH;

`ifdef DECODER_SEQUENCER_GAP_EN
  typedef enum logic [1:0] {IDLE, SCAN, GAP} stateT;
`else
  typedef enum logic [1:0] {IDLE, SCAN} stateT;
`endif

  stateT                 stateQ,   stateD;
  logic [SEL_WIDTH-1:0]  indexQ,   indexD;
  logic [HOLD_WIDTH-1:0] holdCntQ, holdCntD;
  logic [SEL_WIDTH-1:0]  lastQ,    lastD;
  logic [HOLD_WIDTH-1:0] holdQ,    holdD;
  logic [OUT_COUNT-1:0]  outQ,     outD;
  logic                  busyQ,    busyD;
  logic                  doneQ,    doneD;

  logic [SEL_WIDTH-1:0]  nextIndex;
  logic [OUT_COUNT-1:0]  selHot;
  logic [OUT_COUNT-1:0]  nextHot;

  // index never wraps: it only advances while strictly below the captured last
  assign nextIndex = indexQ + 1'b1;

  always_comb begin
    selHot          = '0;
    selHot[bus.sel] = 1'b1;
    nextHot            = '0;
    nextHot[nextIndex] = 1'b1;
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    stateD   = stateQ;
    indexD   = indexQ;
    holdCntD = holdCntQ;
    lastD    = lastQ;
    holdD    = holdQ;
    outD     = outQ;
    busyD    = busyQ;
    doneD    = 1'b0;

    if (!bus.enable) begin
      stateD   = IDLE;
      indexD   = '0;
      holdCntD = '0;
      outD     = '0;
      busyD    = 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          busyD = 1'b0;
          if (!bus.mode) begin
            outD = selHot;
          end else if (bus.start) begin
            lastD    = bus.last;
            holdD    = bus.hold;
            indexD   = '0;
            holdCntD = '0;
            outD     = {{(OUT_COUNT-1){1'b0}}, 1'b1};
            busyD    = 1'b1;
            stateD   = SCAN;
          end else begin
            outD = '0;
          end
        end

        SCAN: begin
          if (holdCntQ < holdQ) begin
            holdCntD = holdCntQ + 1'b1;
          end else if (indexQ < lastQ) begin
            holdCntD = '0;
`ifdef DECODER_SEQUENCER_GAP_EN
            // break-before-make: drop the strobe here, raise the next one from GAP
            outD   = '0;
            stateD = GAP;
`else
            indexD = nextIndex;
            outD   = nextHot;
`endif
          end else begin
            indexD   = '0;
            holdCntD = '0;
            outD     = '0;
            busyD    = 1'b0;
            doneD    = 1'b1;
            stateD   = IDLE;
          end
        end

`ifdef DECODER_SEQUENCER_GAP_EN
        GAP: begin
          indexD = nextIndex;
          outD   = nextHot;
          stateD = SCAN;
        end
`endif

        default: begin
          stateD = IDLE;
          outD   = '0;
          busyD  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stateQ   <= IDLE;
      indexQ   <= '0;
      holdCntQ <= '0;
      lastQ    <= '0;
      holdQ    <= '0;
      outQ     <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      indexQ   <= indexD;
      holdCntQ <= holdCntD;
      lastQ    <= lastD;
      holdQ    <= holdD;
      outQ     <= outD;
      busyQ    <= busyD;
      doneQ    <= doneD;
    end
  end

  assign bus.decoder_out = outQ;
  assign bus.busy        = busyQ;
  assign bus.done        = doneQ;
endmodule

// File: doc/decoder_sequencer.md
# decoder_sequencer

Registered, parametrised one-hot decoder with a built-in strobe sequencer. It is the successor to the combinational 4-to-16 decoder. In direct mode it drives one registered output selected by `sel`. In scan mode it walks a single active strobe across outputs 0..`last`, holding each one for a programmable number of cycles. It sits between control logic and banks of chip-selects or register-enable lines that need glitch-free, stepped strobes.

## Interface
Parameters:
- `SEL_WIDTH`, default 4: select width.
  - Output count `OUT_COUNT` = 2**`SEL_WIDTH`, a localparam that cannot be overridden.
- `HOLD_WIDTH`, default 8: width of the per-strobe hold count.

Ports:
- `clock`  in  1: sole clock; all logic on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `enable`  in  1: global enable.
  - Low forces all outputs to 0 from the next edge.
  - Low aborts any scan in progress.
- `mode`  in  1: 0 = direct decode, 1 = scan. Sampled only in IDLE.
- `sel`  in  `SEL_WIDTH`: direct-mode index.
- `start`  in  1: scan request. Accepted only in IDLE with `mode`=1 and `enable`=1.
- `last`  in  `SEL_WIDTH`: final scan index. Captured when `start` is accepted.
- `hold`  in  `HOLD_WIDTH`: each strobe is held for `hold`+1 cycles. Captured when `start` is accepted.
- `decoder_out`  out  `OUT_COUNT`: one-hot or all-zero, registered.
- `busy`  out  1: high in SCAN (and GAP when compiled in).
- `done`  out  1: one-cycle pulse when a scan completes normally.

## Operation
- Reset values: `decoder_out`=0, `busy`=0, `done`=0, state=IDLE, index and hold counter = 0.
- States: IDLE, SCAN, GAP (GAP exists only with the macro defined).
- IDLE with `mode`=0:
  - `decoder_out` <= (`enable` ? 1 << `sel` : 0) every cycle.
  - `start` is ignored.
- IDLE with `mode`=1 and no accepted `start`: `decoder_out` <= 0.
- IDLE with `mode`=1, `enable`=1 and `start`=1:
  - capture `last` and `hold`;
  - set index=0 and hold counter=0;
  - `decoder_out` <= bit 0;
  - go to SCAN, `busy` <= 1.
- SCAN, each cycle with `enable`=1:
  - If the hold counter is below the captured hold value: increment the counter; the same bit stays asserted.
  - Else, if index is below the captured last value: index+1, counter=0, `decoder_out` <= 1 << (index+1).
  - Else: `decoder_out` <= 0, `busy` <= 0, `done` <= 1 for one cycle, go to IDLE.
- `enable`=0 in any state:
  - next edge: `decoder_out`=0, `busy`=0;
  - go to IDLE with no `done` pulse;
  - index and counter are cleared.
- In SCAN, `start`, `mode`, `sel`, `last` and `hold` are ignored.
- `start` on the same edge that `done` asserts is ignored. A new scan can begin on the first IDLE cycle.
- Captured `last`=0 gives a single strobe on bit 0.
- Captured `last`=`OUT_COUNT`-1 visits every output; index never wraps.
- `reset_n` low mid-scan: all registers take their reset values on that edge, with no `done` pulse.
- Invariant: `decoder_out` has at most one bit set in every cycle.

## Timing
- Direct mode: 1-cycle latency from `sel`/`enable` to `decoder_out`.
- Scan: the edge that accepts `start` asserts bit 0.
- Each strobe is held exactly `hold`+1 cycles.
- Without the gap feature, a scan lasts (`last`+1)*(`hold`+1) cycles.
- `done` asserts on the edge after the final strobe's last cycle, together with `decoder_out`=0.
- Abort: outputs are cleared 1 cycle after `enable` falls.

## Configuration
- `DECODER_SEQUENCER_GAP_EN` defined:
  - After each strobe except the last, the block enters GAP for exactly one cycle with `decoder_out`=0 and `busy`=1, then asserts the next bit (break-before-make).
  - Scan length becomes (`last`+1)*(`hold`+1)+`last` cycles.
  - `enable` low in GAP aborts as it does in SCAN.
- Not defined:
  - The GAP state and its logic are absent.
  - Consecutive strobes are back-to-back: the next bit asserts on the edge that deasserts the previous one.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `enable`=1, `sel`=5 -> `decoder_out`=0, `busy`=0, `done`=0. One cycle after release -> `decoder_out`=16'h0020.
- Direct sweep: `mode`=0, `enable`=1, `sel`=0..15 over consecutive cycles -> `decoder_out`=1<<`sel` one cycle later. `enable`=0 -> 0 the next cycle.
- Scan: `last`=3, `hold`=2, `start` pulse. Without the macro: bits 0..3 each high 3 cycles, `busy` high 12 cycles, `done` high in cycle 13. With the macro: 3 zero gap cycles interleaved and `done` in cycle 16.
- Edge parameters: `last`=0, `hold`=0 -> bit 0 high 1 cycle, then `done`. `last`=15, `hold`=0 -> 16 consecutive strobes, bit 15 last, no wrap.
- Abort and ignore:
  - `enable`=0 during the strobe on bit 2 -> outputs 0 next cycle, `busy`=0, no `done`.
  - `start`, `last` and `hold` changes while `busy`=1 -> no effect on the running scan.
- Reset mid-scan: `reset_n`=0 during strobe 1 -> all outputs 0 on that edge. After release, a fresh `start` begins again at bit 0.
